// File: rtl/lut_minterm_engine_if.sv
// lut_minterm_engine_if: write, evaluate and sweep signals of the minterm engine
interface lut_minterm_engine_if #(parameter int N_IN = 7);
  logic            wr_en;
  logic [N_IN-1:0] wr_addr;
  logic            wr_data;
  logic            wr_ready;
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_ready;
  logic            out_valid;
  logic            out;
  logic            start;
  logic            busy;
  logic            done;
  logic [N_IN:0]   minterm_count;
  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_vec, start,
    input  wr_ready, in_ready, out_valid, out, busy, done, minterm_count
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_vec, start,
    output wr_ready, in_ready, out_valid, out, busy, done, minterm_count
  );
endinterface

// File: rtl/lut_minterm_engine.sv
// lut_minterm_engine: 2^N_IN-entry truth table with registered lookup; LUT_MINTERM_SWEEP_EN adds the minterm-count sweep
module lut_minterm_engine #(
  parameter int N_IN = 7
) (
  input  logic               clk,
  input  logic               reset,
  lut_minterm_engine_if.slave bus
);
  localparam int DEPTH = 1 << N_IN;
  logic [DEPTH-1:0] table_q;
  logic             out_q;
  logic             out_valid_q;
  logic             busy;
  assign bus.wr_ready  = ~busy;
  assign bus.in_ready  = ~busy;
  assign bus.busy      = busy;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  // Lookup reads the pre-edge table, so a same-address write lands after the read
  always_ff @(posedge clk) begin
    if (reset) begin
      table_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.wr_en && !busy) table_q[bus.wr_addr] <= bus.wr_data;
      out_valid_q <= bus.in_valid && !busy;
      if (bus.in_valid && !busy) out_q <= table_q[bus.in_vec];
    end
  end
`ifdef LUT_MINTERM_SWEEP_EN
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
  state_t          state_q, state_d;
  logic [N_IN-1:0] addr_q;
  logic [N_IN:0]   acc_q;
  logic [N_IN:0]   count_q;
  logic            done_q;
  assign busy              = state_q != S_IDLE;
  assign bus.done          = done_q;
  assign bus.minterm_count = count_q;
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == S_IDLE  ? (bus.start ? S_SWEEP : S_IDLE) :
              state_q == S_SWEEP ? (&addr_q ? S_DONE : S_SWEEP) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= state_q == S_DONE;
      if (state_q == S_IDLE) begin
        addr_q <= '0;
        acc_q  <= '0;
      end
      if (state_q == S_SWEEP) begin
        acc_q  <= acc_q + (N_IN+1)'(table_q[addr_q]);
        addr_q <= &addr_q ? addr_q : addr_q + N_IN'(1);
      end
      if (state_q == S_DONE) count_q <= acc_q;
    end
  end
`else
  logic unused_start;
  assign unused_start      = bus.start;
  assign busy              = 1'b0;
  assign bus.done          = 1'b0;
  assign bus.minterm_count = '0;
`endif
endmodule

// File: tb/tb_lut_minterm_engine.sv
// tb_lut_minterm_engine: directed checks of table write, lookup and (when built) the minterm sweep
module tb_lut_minterm_engine;
  localparam int N = 7;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  lut_minterm_engine_if #(.N_IN(N)) bus ();
  lut_minterm_engine #(.N_IN(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wr(input int a, input logic d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = N'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic eval(input int v, input logic exp, input string tag);
    bus.in_valid = 1'b1;
    bus.in_vec   = N'(v);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_out"}, 32'(bus.out), 32'(exp));
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
  endtask
  task automatic run_sweep(input int wr_at, input int st_at, output int bc, output int da);
    bc = 0;
    da = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 300 && da < 0; c++) begin
      if (bus.busy) bc++;
      if (c == wr_at) check("wr_ready_busy", 32'(bus.wr_ready), 0);
      bus.wr_en   = (c == wr_at);
      bus.wr_addr = N'(100);
      bus.wr_data = 1'b1;
      bus.start   = (c == st_at);
      tick();
      if (bus.done) da = c + 1;
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask
  initial begin
    int vecs [4] = '{0, 1, 3, 127};
    logic exps [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int bc;
    int da;
    int seen;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    bus.start = 1'b0;
    repeat (3) tick();
    check("rst_out", 32'(bus.out), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_count", 32'(bus.minterm_count), 0);
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    reset = 1'b0;
    tick();
    eval(0, 1'b0, "clr0");
    eval(5, 1'b0, "clr5");
    eval(127, 1'b0, "clr127");
    tick();
    check("idle_valid", 32'(bus.out_valid), 0);
    wr(0, 1'b1);
    wr(3, 1'b1);
    wr(127, 1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_vec = N'(vecs[i]);
      tick();
      check($sformatf("b2b%0d_out", vecs[i]), 32'(bus.out), 32'(exps[i]));
      check($sformatf("b2b%0d_valid", vecs[i]), 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("hold_out", 32'(bus.out), 1);
    check("hold_valid", 32'(bus.out_valid), 0);
    bus.wr_en = 1'b1;
    bus.wr_addr = N'(9);
    bus.wr_data = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec = N'(9);
    tick();
    bus.wr_en = 1'b0;
    check("rbw_old", 32'(bus.out), 0);
    tick();
    bus.in_valid = 1'b0;
    check("rbw_new", 32'(bus.out), 1);
`ifdef LUT_MINTERM_SWEEP_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    eval(9, 1'b0, "rst_clears9");
    for (int i = 0; i < 66; i++) wr(i, 1'b1);
    run_sweep(50, -1, bc, da);
    check("sweep66_busy_cycles", 32'(bc), 129);
    check("sweep66_done_at", 32'(da), 129);
    check("sweep66_busy_at_done", 32'(bus.busy), 0);
    check("sweep66_count", 32'(bus.minterm_count), 66);
    tick();
    check("done_one_cycle", 32'(bus.done), 0);
    check("count_holds", 32'(bus.minterm_count), 66);
    eval(100, 1'b0, "dropped_write");
    for (int i = 66; i < 128; i++) wr(i, 1'b1);
    run_sweep(-1, 60, bc, da);
    check("sweep128_done_at", 32'(da), 129);
    check("sweep128_count", 32'(bus.minterm_count), 128);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (40) tick();
    check("abort_busy_before", 32'(bus.busy), 1);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_count", 32'(bus.minterm_count), 0);
    seen = 0;
    repeat (150) begin
      tick();
      if (bus.done || bus.busy) seen = 1;
    end
    check("abort_no_done", 32'(seen), 0);
    eval(5, 1'b0, "abort_cleared5");
    eval(127, 1'b0, "abort_cleared127");
`else
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_vec = N'(i[0] ? 1 : 9);
      check("off_in_ready", 32'(bus.in_ready), 1);
      tick();
      check("off_busy", 32'(bus.busy), 0);
      check("off_done", 32'(bus.done), 0);
      check("off_count", 32'(bus.minterm_count), 0);
      check("off_valid", 32'(bus.out_valid), 1);
      check("off_out", 32'(bus.out), i[0] ? 0 : 1);
    end
    bus.in_valid = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
